// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that shares one start/busy 32x32 multiplier among NUM_REQ requesters,
// returning each 64-bit product tagged with its owner id, with a watchdog on multiplier busy.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_product,
  output logic                    resp_err,
  output logic                    mult_start,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic                    mult_busy,
  input  logic [63:0]             mult_product,
  output logic                    arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;
  logic [31:0]     r_mult_a;
  logic [31:0]     r_mult_b;
  logic [ID_W-1:0] r_resp_id;
  logic [63:0]     r_resp_product;
  logic            r_resp_err;
  logic [7:0]      r_wait_cnt;

  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic [ID_W:0]   w_idx;
  logic            w_grant;
  logic            w_done;
  logic            w_timeout;
  logic [7:0]      w_cnt_inc;

  assign w_cnt_inc = r_wait_cnt + 8'd1;

  // Round-robin search from r_rr_ptr. Iterating downwards lets the lowest rotated
  // offset overwrite the others, so no early exit is needed.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      if (w_idx >= (ID_W + 1)'(NUM_REQ)) w_idx = w_idx - (ID_W + 1)'(NUM_REQ);
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    mult_start   = 1'b0;
    req_ack      = '0;
    resp_valid   = 1'b0;
    arb_busy     = 1'b1;
    w_grant      = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        arb_busy = 1'b0;
        if (w_found && !mult_busy) begin
          w_grant      = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mult_start       = 1'b1;
        req_ack[r_owner] = 1'b1;
        w_state_next     = S_WAIT;
      end
      S_WAIT: begin
        if (!mult_busy) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end else if (w_cnt_inc == 8'(TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_mult_a       <= '0;
      r_mult_b       <= '0;
      r_resp_id      <= '0;
      r_resp_product <= '0;
      r_resp_err     <= 1'b0;
      r_wait_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner  <= w_winner;
            r_mult_a <= req_a[{w_winner, 5'b0} +: 32];
            r_mult_b <= req_b[{w_winner, 5'b0} +: 32];
          end
        end
        S_ISSUE: r_wait_cnt <= '0;
        S_WAIT: begin
          if (w_done) begin
            r_resp_product <= mult_product;
            r_resp_err     <= 1'b0;
            r_resp_id      <= r_owner;
          end else if (w_timeout) begin
            r_resp_product <= '0;
            r_resp_err     <= 1'b1;
            r_resp_id      <= r_owner;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          // Explicit compare so the wrap is correct for non-power-of-two NUM_REQ.
          if (r_owner == ID_W'(NUM_REQ - 1)) r_rr_ptr <= '0;
          else                               r_rr_ptr <= r_owner + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mult_a       = r_mult_a;
  assign mult_b       = r_mult_b;
  assign resp_id      = r_resp_id;
  assign resp_product = r_resp_product;
  assign resp_err     = r_resp_err;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter/sequencer that shares one 32x32 fast multiplier (start/busy interface, 64-bit product register) among NUM_REQ requesters. It accepts one request at a time, latches and holds the operands, pulses start, and waits for busy to fall. It then returns the 64-bit product tagged with the requester id. A watchdog aborts the operation if busy stays high for too long.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must equal ceil(log2(NUM_REQ))
TIMEOUT, 15, maximum WAIT cycles with mult_busy high before abort (4..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request level; held until matching req_ack
req_a  in  32*NUM_REQ  operand A, slice i = [32*i+31:32*i]
req_b  in  32*NUM_REQ  operand B, same slicing
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; operands of that requester are captured
resp_valid  out  1  1-cycle pulse; result available
resp_id  out  ID_W  owner of the result
resp_product  out  64  product; held until next resp_valid
resp_err  out  1  qualifies resp_valid; 1 = timeout abort, product is 0
mult_start  out  1  start to the multiplier
mult_a  out  32  operand A to the multiplier; registered, stable from ISSUE to end of WAIT
mult_b  out  32  operand B to the multiplier; same timing as mult_a
mult_busy  in  1  multiplier busy
mult_product  in  64  multiplier product register
arb_busy  out  1  high in every state except IDLE

Behaviour:
- One clock: clk. Reset is synchronous and active-high: reset.
- Reset values (synchronous, any state): state=IDLE, rr_ptr=0, owner=0, mult_a/mult_b=0, req_ack=0, resp_valid=0, resp_id=0, resp_product=0, resp_err=0, wait_cnt=0.
- Reset mid-operation aborts the transaction. No response is issued. The multiplier shares the same reset.
- States and transitions:
  IDLE: if any req_valid and mult_busy=0, pick a winner (below). Latch req_a/req_b of the winner into mult_a/mult_b, set owner, go to ISSUE. Otherwise stay in IDLE.
  ISSUE (1 cycle): req_ack[owner]=1, mult_start=1, wait_cnt cleared. Go to WAIT.
  WAIT: if mult_busy=0, latch mult_product into resp_product, set resp_err=0, go to RESP. Else increment wait_cnt. If wait_cnt reaches TIMEOUT, set resp_product=0 and resp_err=1, then go to RESP.
  RESP (1 cycle): resp_valid=1, resp_id=owner. Set rr_ptr=owner+1, modulo NUM_REQ. Go to IDLE.
- mult_start is decoded combinationally from state=ISSUE. req_ack and resp_valid are high only in their own states.
- The multiplier raises busy the cycle after start, so the first WAIT cycle normally sees busy=1.
- Arbitration is round-robin: the lowest index at or above rr_ptr with req_valid=1 wins; the search wraps to 0. rr_ptr changes only in RESP.
- Only one transaction is in flight. Requests arriving during ISSUE, WAIT or RESP wait in IDLE arbitration.
- Latency, from the request being sampled in IDLE at cycle 0:
  - ack and start at cycle 1;
  - resp_valid at cycle 3+B, where B is the number of busy cycles (B=1 when both MSWs are 0, B=4 for a full operation).
- Minimum spacing between two grants is 4+B cycles.
- Boundary conditions:
  - req_valid dropped after the IDLE capture: the transaction still completes and is acked.
  - After a timeout, IDLE holds off granting until mult_busy=0.
  - Simultaneous requests from all requesters: each is served once per rotation.
  - NUM_REQ not a power of two: pointer wrap uses an explicit compare, not bit truncation.

Test Plan:
- Reset, then req_valid[0]=1, a=3, b=5 (both MSWs 0, model B=1) -> req_ack[0] at cycle 1, resp_valid at cycle 4, resp_id=0, product=15, resp_err=0.
- req_valid[2]=1, a=0xFFFFFFFF, b=0xFFFFFFFF (B=4) -> resp_valid at cycle 7, product=0xFFFFFFFE00000001, resp_id=2.
- All 4 requests held high continuously -> ack order 0,1,2,3,0, and 5 responses with matching ids.
- Multiplier model holding busy high indefinitely -> resp_valid with resp_err=1 and product 0 after 15 WAIT cycles. No new grant until the model drops busy.
- reset asserted during WAIT -> next cycle all outputs are at reset values. No resp_valid. A new request is then served from index 0.
- req_valid[1] pulsed for 1 cycle in IDLE with mult_busy=0 -> transaction still acked and responded, and mult_a/mult_b stay stable throughout WAIT.
